mult_div_unit: RTL

//  Iterative unsigned multiply/divide unit with architectural HI/LO registers. It sits downstream of

---
 rtl/mult_div_unit_pkg.sv | 7 +
 rtl/md_iter_step.sv | 28 ++
 rtl/mult_div_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared types and constants for the iterative multiply/divide unit
package mult_div_unit_pkg;
  typedef enum logic [0:0] {MD_MULTU, MD_DIVU} md_op_t;
  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;
  localparam int MD_WIDTH = 32;
  localparam int MD_LATENCY = MD_WIDTH + 1;
endpackage

// File: rtl/md_iter_step.sv
// md_iter_step: one combinational shift/add (MULTU) or restoring shift/subtract (DIVU) iteration
module md_iter_step
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  md_op_t           op,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] sreg,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] sreg_next
);
  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  // Multiply adds b when the low multiplier bit is set, then shifts {carry,acc,multiplier} right;
  // divide shifts the next dividend bit into the remainder and keeps the subtraction unless it went negative.
  always_comb begin
    sum       = acc + {1'b0, (sreg[0] ? b : '0)};
    shifted   = {acc, sreg[WIDTH-1]};
    diff      = shifted - {2'b00, b};
    acc_next  = (op == MD_MULTU) ? {1'b0, sum[WIDTH:1]}
              : (diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0]);
    sreg_next = (op == MD_MULTU) ? {sum[0], sreg[WIDTH-1:1]}
              : {sreg[WIDTH-2:0], ~diff[WIDTH+1]};
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative unsigned MULTU/DIVU engine with architectural HI/LO and core stall
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  input  logic             read_hilo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             stall
);
  localparam int CW = $clog2(WIDTH);
  md_state_t        state;
  md_op_t           op_q;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] sreg_next;
  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .op        (op_q),
    .acc       (acc),
    .sreg      (sreg),
    .b         (b_q),
    .acc_next  (acc_next),
    .sreg_next (sreg_next)
  );
  assign stall = busy & (start | read_hilo | hi_we | lo_we);
  // Control FSM: capture operands, iterate WIDTH times, then publish HI/LO with a one-cycle done.
  // A divisor of zero naturally yields an all-ones quotient and the dividend as remainder.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= MD_IDLE;
      op_q        <= MD_MULTU;
      count       <= '0;
      acc         <= '0;
      sreg        <= '0;
      b_q         <= '0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start) begin
            state       <= MD_RUN;
            op_q        <= op;
            acc         <= '0;
            sreg        <= a;
            b_q         <= b;
            count       <= CW'(WIDTH - 1);
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
          end else begin
            if (hi_we) hi <= wd;
            if (lo_we) lo <= wd;
          end
        end
        MD_RUN: begin
          acc   <= acc_next;
          sreg  <= sreg_next;
          count <= count - CW'(1);
          if (count == '0) state <= MD_DONE;
        end
        MD_DONE: begin
          hi          <= acc[WIDTH-1:0];
          lo          <= sreg;
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= (op_q == MD_DIVU) && (b_q == '0);
          state       <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end
endmodule
